fixed3_norm_v2: RTL and testbench

- Sequential normalizer for a 3-component signed fixed-point vector (Fixed3); returns v/|v| in the same format.
- Used by the shading/lighting path for light directions and surface normals.
- One vector in flight: strobe-triggered, valid-pulse result, fixed latency, no back-pressure.

---
 rtl/fixed_pkg.sv | 44 ++++
 rtl/fixed_isqrt64_seq.sv | 53 +++++
 rtl/fixed3_norm_v2.sv | 158 +++++++++++++++
 tb/tb_fixed3_norm_v2.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared Q16.16 fixed-point types for the shading/lighting path:
// scalar Fixed, 3-vector Fixed3, constructors and the normalizer state encoding.
package fixed_pkg;

   localparam int FIXED_WIDTH      = 32;
   localparam int FIXED_FRAC_WIDTH = FIXED_WIDTH / 2;

   // 1.0 in Q16.16, the largest magnitude a normalized component may take
   localparam logic [FIXED_FRAC_WIDTH:0] FIXED_ONE = {1'b1, {FIXED_FRAC_WIDTH{1'b0}}};

   localparam int SQRT_EDGES  = 32;
   localparam int RECIP_EDGES = 48;

   typedef struct packed {
      logic signed [FIXED_WIDTH-1:0] Value;
   } Fixed;

   typedef struct packed {
      Fixed [2:0] Dim;
   } Fixed3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SQSUM,
      ST_SQRT,
      ST_RECIP,
      ST_MUL
   } norm_state_t;

   function automatic Fixed _Fixed(input int i);
      Fixed f;
      f.Value = i;
      return f;
   endfunction

   function automatic Fixed3 _Fixed3(input Fixed x, input Fixed y, input Fixed z);
      Fixed3 r;
      r.Dim[0] = x;
      r.Dim[1] = y;
      r.Dim[2] = z;
      return r;
   endfunction

endpackage

// File: rtl/fixed_isqrt64_seq.sv
// Bit-serial restoring integer square root: floor(sqrt(i_rad)), 64-bit in, 32-bit out,
// one root bit per edge for 32 edges after i_start.
module fixed_isqrt64_seq
   import fixed_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [63:0] i_rad,
   output logic [31:0] o_root,
   output logic        o_done
);

   logic [63:0] r_rad;
   logic [33:0] r_rem;
   logic [31:0] r_root;
   logic [5:0]  r_cnt;

   logic [35:0] w_rem_sh;
   logic [35:0] w_trial;
   logic        w_fit;
   logic [33:0] w_rem_nx;

   // Bring down the next two radicand bits and try appending a 1 to the root
   assign w_rem_sh = {r_rem, r_rad[63:62]};
   assign w_trial  = {2'b00, r_root, 2'b01};
   assign w_fit    = (w_rem_sh >= w_trial);
   assign w_rem_nx = w_fit ? 34'(w_rem_sh - w_trial) : w_rem_sh[33:0];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rad  <= '0;
         r_rem  <= '0;
         r_root <= '0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_rad  <= i_rad;
         r_rem  <= '0;
         r_root <= '0;
         r_cnt  <= 6'(SQRT_EDGES);
      end else if (r_cnt != 6'd0) begin
         r_rad  <= {r_rad[61:0], 2'b00};
         r_rem  <= w_rem_nx;
         r_root <= {r_root[30:0], w_fit};
         r_cnt  <= r_cnt - 6'd1;
      end
   end

   // High in the cycle whose closing edge writes the final root bit
   assign o_done = (r_cnt == 6'd1);
   assign o_root = r_root;

endmodule

// File: rtl/fixed3_norm_v2.sv
// fixed3_norm_v2: sequential v/|v| for a Q16.16 3-vector, result 82 edges after the accepting edge.
// Build option FIXED3_NORM_ROUND_EN: round-to-nearest reciprocal and final multiply.
module fixed3_norm_v2
   import fixed_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  strobe,
   input  Fixed3 v,
   output Fixed3 ov,
   output logic  valid,
   output logic  busy
);

   // Reciprocal width: floor(2^48 / L) reaches 2^48 when L == 1
   localparam int QW = 49;

   norm_state_t r_state;
   norm_state_t w_state_nx;

   Fixed3          r_v;
   Fixed3          r_ov;
   logic           r_valid;
   logic [5:0]     r_cnt;
   logic [31:0]    r_rem;
   logic [QW-1:0]  r_quo;

   logic [31:0]    w_mag [3];
   logic [63:0]    w_sq_sum;
   logic           w_sq_start;
   logic           w_sq_done;
   logic [31:0]    w_l;
   logic           w_l_zero;
   logic           w_l_one;
   logic           w_first;
   logic [31:0]    w_rem_in;
   logic [32:0]    w_rem_dbl;
   logic           w_qbit;
   logic [31:0]    w_rem_nx;
   logic [QW-1:0]  w_recip;

   function automatic logic [31:0] f_mag(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

   // R carries 1/|v| with 32 fractional bits, so the product is renormalised by 32
   function automatic logic [16:0] f_scale(input logic [31:0] mag, input logic [QW-1:0] recip);
      logic [80:0] prod;
      prod = {49'b0, mag} * {32'b0, recip};
`ifdef FIXED3_NORM_ROUND_EN
      prod = prod + 81'h8000_0000;
`endif
      if (prod[80:32] > 49'(FIXED_ONE))
         return FIXED_ONE;
      return prod[48:32];
   endfunction

   function automatic logic [31:0] f_signed(input logic [16:0] mag, input logic neg);
      logic [31:0] m;
      m = {15'b0, mag};
      return neg ? (~m + 32'd1) : m;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++)
         w_mag[i] = f_mag(r_v.Dim[i].Value);
   end

   assign w_sq_sum = ({32'b0, w_mag[0]} * {32'b0, w_mag[0]})
                   + ({32'b0, w_mag[1]} * {32'b0, w_mag[1]})
                   + ({32'b0, w_mag[2]} * {32'b0, w_mag[2]});

   fixed_isqrt64_seq u_isqrt (
      .i_clk   (clk),
      .i_reset (reset),
      .i_start (w_sq_start),
      .i_rad   (w_sq_sum),
      .o_root  (w_l),
      .o_done  (w_sq_done)
   );

   // Divider: the leading quotient bit (2^48 >= L only for L == 1) is folded into the first edge
   assign w_l_zero  = (w_l == 32'd0);
   assign w_l_one   = (w_l == 32'd1);
   assign w_first   = (r_cnt == 6'd0);
   assign w_rem_in  = w_first ? (w_l_one ? 32'd0 : 32'd1) : r_rem;
   assign w_rem_dbl = {w_rem_in, 1'b0};
   assign w_qbit    = !w_l_zero && (w_rem_dbl >= {1'b0, w_l});
   assign w_rem_nx  = w_qbit ? 32'(w_rem_dbl - {1'b0, w_l}) : w_rem_dbl[31:0];

`ifdef FIXED3_NORM_ROUND_EN
   // Guard bit from the final remainder: fraction >= 1/2 rounds the reciprocal up
   assign w_recip = r_quo + QW'(!w_l_zero && ({r_rem, 1'b0} >= {1'b0, w_l}));
`else
   assign w_recip = r_quo;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_sq_start = 1'b0;
      case (r_state)
         ST_IDLE:  if (strobe) w_state_nx = ST_SQSUM;
         ST_SQSUM: begin
            w_sq_start = 1'b1;
            w_state_nx = ST_SQRT;
         end
         ST_SQRT:  if (w_sq_done) w_state_nx = ST_RECIP;
         ST_RECIP: if (r_cnt == 6'(RECIP_EDGES - 1)) w_state_nx = ST_MUL;
         ST_MUL:   w_state_nx = ST_IDLE;
         default:  w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v     <= '0;
         r_ov    <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (strobe)
                  r_v <= v;
            end
            ST_SQRT: begin
               r_cnt <= '0;
            end
            ST_RECIP: begin
               r_cnt <= r_cnt + 6'd1;
               r_rem <= w_rem_nx;
               r_quo <= w_first ? {{(QW-2){1'b0}}, w_l_one, w_qbit} : {r_quo[QW-2:0], w_qbit};
            end
            ST_MUL: begin
               for (int i = 0; i < 3; i++)
                  r_ov.Dim[i].Value <= f_signed(f_scale(w_mag[i], w_recip), r_v.Dim[i].Value[31]);
               r_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ov    = r_ov;
   assign valid = r_valid;
   assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fixed3_norm_v2.sv
// Self-checking bench for fixed3_norm_v2: directed cases plus random vectors
// against a real-arithmetic model of v/|v| in Q16.16.
module tb_fixed3_norm_v2;
   import fixed_pkg::*;

   logic  clk;
   logic  reset;
   logic  strobe;
   Fixed3 v;
   Fixed3 ov;
   logic  valid;
   logic  busy;

   int n_cmp = 0;
   int n_bad = 0;

   fixed3_norm_v2 dut (
      .clk    (clk),
      .reset  (reset),
      .strobe (strobe),
      .v      (v),
      .ov     (ov),
      .valid  (valid),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
      longint d;
      n_cmp++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, obs, exp, tol);
      end
   endtask

   // Exact normalized component, rounded to the nearest Q16.16 step
   function automatic longint ref_comp(input int c, input int x, input int y, input int z);
      real m;
      real r;
      if (x == 0 && y == 0 && z == 0) return 0;
      m = $sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y) + $itor(z) * $itor(z));
      r = $itor(c) * 65536.0 / m;
      if (r >= 0.0) return longint'($rtoi(r + 0.5));
      return -longint'($rtoi(-r + 0.5));
   endfunction

   task automatic check_ov(input string tag, input int x, input int y, input int z, input int tol);
      int c;
      for (int i = 0; i < 3; i++) begin
         c = (i == 0) ? x : ((i == 1) ? y : z);
         check($sformatf("%s_ov%0d", tag, i), longint'(ov.Dim[i].Value), ref_comp(c, x, y, z), tol);
      end
   endtask

   // Leaves the bench just after the accepting edge
   task automatic start_vec(input int x, input int y, input int z);
      @(negedge clk);
      v = _Fixed3(_Fixed(x), _Fixed(y), _Fixed(z));
      strobe = 1'b1;
      @(posedge clk);
      #1 strobe = 1'b0;
   endtask

   task automatic wait_valid(output int lat, output int busy_low);
      lat = 0;
      busy_low = 0;
      for (int n = 1; n <= 150; n++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            lat = n;
            break;
         end
         if (!busy) busy_low++;
      end
   endtask

   task automatic count_valid(input int cycles, output int hits);
      hits = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (valid) hits++;
      end
   endtask

   task automatic run_vec(input string tag, input int x, input int y, input int z, input int tol);
      int lat;
      int blow;
      start_vec(x, y, z);
      wait_valid(lat, blow);
      check({tag, "_lat"}, lat, 82, 0);
      check({tag, "_busyhold"}, blow, 0, 0);
      check({tag, "_busydone"}, busy, 0, 0);
      check_ov(tag, x, y, z, tol);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, valid, 0, 0);
   endtask

   initial begin
      int lat;
      int blow;
      int hits;
      int c [3];
      longint a;
      longint mx;

      reset  = 1'b1;
      strobe = 1'b0;
      v      = '0;
      #12;
      check("rst_valid", valid, 0, 0);
      check("rst_busy", busy, 0, 0);
      for (int i = 0; i < 3; i++)
         check($sformatf("rst_ov%0d", i), longint'(ov.Dim[i].Value), 0, 0);
      @(negedge clk);
      reset = 1'b0;

      run_vec("v856", 8 * 65536, 5 * 65536, 6 * 65536, 4);
      run_vec("unit", 65536, 0, 0, 0);
      run_vec("m34", -3 * 65536, 4 * 65536, 0, 4);
      run_vec("zero", 0, 0, 0, 0);
      run_vec("big", 30000 * 65536, -30000 * 65536, 30000 * 65536, 4);
      run_vec("mneg", 32'sh8000_0000, 0, 0, 0);
      run_vec("mneg3", 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 4);

      // Second strobe ten cycles in is ignored
      start_vec(2 * 65536, -65536, 2 * 65536);
      repeat (9) @(posedge clk);
      #1;
      v = _Fixed3(_Fixed(65536), _Fixed(65536), _Fixed(0));
      strobe = 1'b1;
      @(posedge clk);
      #1 strobe = 1'b0;
      wait_valid(lat, blow);
      check("ign_lat", lat, 72, 0);
      check_ov("ign", 2 * 65536, -65536, 2 * 65536, 4);
      count_valid(100, hits);
      check("ign_extra", hits, 0, 0);

      // Reset forty cycles into an operation aborts it
      start_vec(5 * 65536, 7 * 65536, -65536);
      repeat (39) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_valid", valid, 0, 0);
      check("abort_busy", busy, 0, 0);
      for (int i = 0; i < 3; i++)
         check($sformatf("abort_ov%0d", i), longint'(ov.Dim[i].Value), 0, 0);
      @(negedge clk);
      reset = 1'b0;
      count_valid(120, hits);
      check("abort_novalid", hits, 0, 0);

      // New strobe in the valid cycle is accepted
      start_vec(65536, 2 * 65536, 2 * 65536);
      wait_valid(lat, blow);
      check("b2b_lat1", lat, 82, 0);
      check_ov("b2b1", 65536, 2 * 65536, 2 * 65536, 4);
      v = _Fixed3(_Fixed(-6 * 65536), _Fixed(0), _Fixed(8 * 65536));
      strobe = 1'b1;
      @(posedge clk);
      #1 strobe = 1'b0;
      check("b2b_pulse", valid, 0, 0);
      check("b2b_busy", busy, 1, 0);
      wait_valid(lat, blow);
      check("b2b_lat2", lat, 82, 0);
      check_ov("b2b2", -6 * 65536, 0, 8 * 65536, 4);

      for (int k = 0; k < 10; k++) begin
         mx = 0;
         for (int i = 0; i < 3; i++) begin
            c[i] = int'($urandom) >>> $urandom_range(0, 12);
            a = c[i];
            if (a < 0) a = -a;
            if (a > mx) mx = a;
         end
         if (mx < (longint'(1) << 18)) c[0] = 1 << 20;
         run_vec($sformatf("rnd%0d", k), c[0], c[1], c[2], 4);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
